// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests, orders branch/trap
// redirects behind in-flight stalls, counts stall cycles and guards against a hung data bus.
module pipe_ctrl #(
  parameter int WDOG_CYC = 1024,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             br_i,
  input  logic [31:0]      br_addr_i,
  input  logic             trap_i,
  input  logic [31:0]      trap_vec_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             redirect_o,
  output logic [31:0]      redirect_addr_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  localparam int WD_W = $clog2(WDOG_CYC + 1);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH, HALT} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       latch_addr_reg, latch_addr_next;
  logic [31:0]       raddr_reg, raddr_next;
  logic              bus_err_reg;
  logic [CNT_W-1:0]  perf_reg;
  logic [WD_W-1:0]   wdog_cnt_reg;

  logic [5:0]        base_stall;
  logic [5:0]        stall_comb;
  logic              pending;
  logic              wdog_trip;
  logic              flush_comb;

  assign pending = stallreq_id | stallreq_ex | stallreq_mem;

  // Each stall bit freezes its register and everything upstream of the requesting stage.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_base
      if (gi < 3) begin : g_front
        assign base_stall[gi] = pending;
      end else if (gi == 3) begin : g_exmem
        assign base_stall[gi] = stallreq_ex | stallreq_mem;
      end else begin : g_memwb
        assign base_stall[gi] = stallreq_mem;
      end
    end
  endgenerate
  assign base_stall[5] = 1'b0;

  // Counter parks at WDOG_CYC-1 so a held request keeps the trip condition true.
  assign wdog_trip = stallreq_mem && (wdog_cnt_reg == WD_W'(WDOG_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
    end else if (!stallreq_mem) begin
      wdog_cnt_reg <= '0;
    end else if (!wdog_trip) begin
      wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    latch_addr_next = latch_addr_reg;
    raddr_next      = raddr_reg;
    stall_comb      = 6'b000000;
    flush_comb      = 1'b0;
    case (state_reg)
      RUN: begin
        stall_comb = base_stall;
        if (trap_i) begin
          latch_addr_next = trap_vec_i;
          if (pending) begin
            state_next = DRAIN;
          end else begin
            raddr_next = trap_vec_i;
            state_next = FLUSH;
          end
        end else if (br_i && !pending) begin
          raddr_next = br_addr_i;
          state_next = FLUSH;
        end
      end
      DRAIN: begin
        stall_comb = base_stall | 6'b000011;
        if (!pending) begin
          raddr_next = latch_addr_reg;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        flush_comb = 1'b1;
        state_next = RUN;
      end
      HALT: begin
        stall_comb = 6'b111111;
      end
      default: state_next = RUN;
    endcase
    // A hung bus overrides whatever redirect was in progress.
    if (wdog_trip) begin
      state_next      = HALT;
      latch_addr_next = latch_addr_reg;
      raddr_next      = raddr_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RUN;
      latch_addr_reg <= '0;
      raddr_reg      <= '0;
      bus_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      latch_addr_reg <= latch_addr_next;
      raddr_reg      <= raddr_next;
      if (wdog_trip) begin
        bus_err_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_reg <= '0;
    end else if ((stall != 6'b000000) && (perf_reg != {CNT_W{1'b1}})) begin
      perf_reg <= perf_reg + 1'b1;
    end
  end

  assign stall           = rst ? 6'b000000 : stall_comb;
  assign flush           = flush_comb;
  assign redirect_o      = flush_comb;
  assign redirect_addr_o = raddr_reg;
  assign bus_err_o       = bus_err_reg;
  assign perf_stall_cnt  = perf_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model.
module tb_pipe_ctrl;

  localparam int WDOG = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        br_i, trap_i;
  logic [31:0] br_addr_i, trap_vec_i;
  logic [5:0]  stall;
  logic        flush, redirect_o, bus_err_o;
  logic [31:0] redirect_addr_o;
  logic [31:0] perf_stall_cnt;

  logic [5:0]  s_stall;
  logic        s_flush, s_redirect, s_bus_err;
  logic [31:0] s_raddr;
  logic [3:0]  s_perf;

  always #5 clk = ~clk;

  pipe_ctrl #(.WDOG_CYC(WDOG), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .br_i(br_i), .br_addr_i(br_addr_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
    .stall(stall), .flush(flush), .redirect_o(redirect_o), .redirect_addr_o(redirect_addr_o),
    .bus_err_o(bus_err_o), .perf_stall_cnt(perf_stall_cnt)
  );

  // Narrow counter instance used only to observe saturation.
  pipe_ctrl #(.WDOG_CYC(64), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .br_i(br_i), .br_addr_i(br_addr_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
    .stall(s_stall), .flush(s_flush), .redirect_o(s_redirect), .redirect_addr_o(s_raddr),
    .bus_err_o(s_bus_err), .perf_stall_cnt(s_perf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic id, input logic ex, input logic mem,
                        input logic br, input logic [31:0] ba,
                        input logic tr, input logic [31:0] tv);
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    br_i         = br;
    br_addr_i    = ba;
    trap_i       = tr;
    trap_vec_i   = tv;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_halt, m_flush, m_drain;
  logic [31:0] m_target, m_raddr, m_perf;
  int          m_run;
  logic [5:0]  m_exp_stall;

  task automatic model_reset();
    m_halt = 0; m_flush = 0; m_drain = 0;
    m_target = 0; m_raddr = 0; m_perf = 0; m_run = 0; m_exp_stall = 0;
  endtask

  function automatic logic [5:0] model_stall();
    int depth;
    if (m_halt) return 6'h3F;
    if (m_flush) return 6'h00;
    depth = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : 0;
    return 6'((1 << depth) - 1) | (m_drain ? 6'h03 : 6'h00);
  endfunction

  task automatic model_step();
    bit pend;
    pend = stallreq_id | stallreq_ex | stallreq_mem;
    if (m_exp_stall != 0 && m_perf != 32'hFFFF_FFFF) m_perf++;
    m_run = stallreq_mem ? m_run + 1 : 0;
    if (m_halt) begin
    end else if (m_run >= WDOG) begin
      m_halt = 1; m_flush = 0; m_drain = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_drain) begin
      if (!pend) begin m_drain = 0; m_flush = 1; m_raddr = m_target; end
    end else if (trap_i) begin
      m_target = trap_vec_i;
      if (pend) m_drain = 1;
      else begin m_flush = 1; m_raddr = trap_vec_i; end
    end else if (br_i && !pend) begin
      m_flush = 1; m_raddr = br_addr_i;
    end
  endtask

  task automatic model_cycle();
    @(negedge clk);
    m_exp_stall = model_stall();
    check("rnd_stall", 32'(stall), 32'(m_exp_stall));
    check("rnd_flush", 32'(flush), 32'(m_flush && !m_halt));
    check("rnd_redirect", 32'(redirect_o), 32'(m_flush && !m_halt));
    check("rnd_raddr", redirect_addr_o, m_raddr);
    check("rnd_bus_err", 32'(bus_err_o), 32'(m_halt));
    check("rnd_perf", perf_stall_cnt, m_perf);
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asserts reset (async), checks cleared outputs, releases after two edges.
  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_raddr", redirect_addr_o, 0);
    check("rst_bus_err", 32'(bus_err_o), 0);
    check("rst_perf", perf_stall_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    $display("reset applied at %0t", $time);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        id, ex, mem, br, trap;
    logic [31:0] br_addr, trap_vec;
    logic [5:0]  e_stall;
    logic        e_flush, e_redir;
    logic [31:0] e_raddr, e_perf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic id, input logic ex, input logic mem,
                              input logic br, input logic [31:0] ba,
                              input logic tr, input logic [31:0] tv,
                              input logic [5:0] es, input logic ef, input logic er,
                              input logic [31:0] ea, input logic [31:0] ep);
    vec_t v;
    v.id = id; v.ex = ex; v.mem = mem; v.br = br; v.br_addr = ba;
    v.trap = tr; v.trap_vec = tv; v.e_stall = es; v.e_flush = ef; v.e_redir = er;
    v.e_raddr = ea; v.e_perf = ep;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    set_in(v.id, v.ex, v.mem, v.br, v.br_addr, v.trap, v.trap_vec);
    @(negedge clk);
    check($sformatf("vec%0d_stall", idx), 32'(stall), 32'(v.e_stall));
    check($sformatf("vec%0d_flush", idx), 32'(flush), 32'(v.e_flush));
    check($sformatf("vec%0d_redirect", idx), 32'(redirect_o), 32'(v.e_redir));
    check($sformatf("vec%0d_raddr", idx), redirect_addr_o, v.e_raddr);
    check($sformatf("vec%0d_perf", idx), perf_stall_cnt, v.e_perf);
    check($sformatf("vec%0d_bus_err", idx), 32'(bus_err_o), 0);
    $display("vec %0d: stall=%06b flush=%0b redirect=%0b addr=0x%08h perf=%0d",
             idx, stall, flush, redirect_o, redirect_addr_o, perf_stall_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_mem;
    int   halt_cycles;

    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    //                id ex mem br  br_addr       tr trap_vec      stall  fl rd raddr         perf
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         6'h00, 0, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         6'h07, 0, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         6'h07, 0, 0, 32'h0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         6'h00, 0, 0, 32'h0,         2));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,         0, 32'h0,         6'h1F, 0, 0, 32'h0,         2));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         6'h0F, 0, 0, 32'h0,         3));
    vecs.push_back(mk(0, 0, 0, 1, 32'h100,       0, 32'h0,         6'h00, 0, 0, 32'h0,         4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         6'h00, 1, 1, 32'h100,       4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         6'h00, 0, 0, 32'h100,       4));
    vecs.push_back(mk(0, 0, 0, 1, 32'h200,       1, 32'h400,       6'h00, 0, 0, 32'h100,       4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         6'h00, 1, 1, 32'h400,       4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         6'h00, 0, 0, 32'h400,       4));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,         1, 32'h8000_0000, 6'h1F, 0, 0, 32'h400,       4));
    vecs.push_back(mk(0, 0, 1, 1, 32'h300,       0, 32'h0,         6'h1F, 0, 0, 32'h400,       5));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         6'h1F, 0, 0, 32'h400,       6));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         6'h1F, 0, 0, 32'h400,       7));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         6'h03, 0, 0, 32'h400,       8));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         6'h00, 1, 1, 32'h8000_0000, 9));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         6'h00, 0, 0, 32'h8000_0000, 9));
    vecs.push_back(mk(0, 0, 0, 1, 32'h500,       0, 32'h0,         6'h00, 0, 0, 32'h8000_0000, 9));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,         1, 32'h600,       6'h00, 1, 1, 32'h500,       9));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         6'h00, 0, 0, 32'h500,       9));
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Watchdog trips after WDOG consecutive memory-wait cycles and is sticky.
    do_reset();
    set_in(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < WDOG; k++) begin
      @(negedge clk);
      check($sformatf("wdog_pre%0d_bus_err", k), 32'(bus_err_o), 0);
      check($sformatf("wdog_pre%0d_stall", k), 32'(stall), 32'h1F);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("wdog_trip_bus_err", 32'(bus_err_o), 1);
    check("wdog_trip_stall", 32'(stall), 32'h3F);
    $display("watchdog: bus_err=%0b stall=%06b", bus_err_o, stall);
    set_in(0, 0, 0, 1, 32'h900, 1, 32'hA00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("halt_stall", 32'(stall), 32'h3F);
      check("halt_bus_err", 32'(bus_err_o), 1);
      check("halt_flush", 32'(flush), 0);
      check("halt_redirect", 32'(redirect_o), 0);
    end
    do_reset();

    // Reset in the middle of a drain discards the pending trap.
    set_in(0, 0, 1, 0, 0, 1, 32'hDEAD_0000);
    @(posedge clk);
    #1;
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("drain_stall", 32'(stall), 32'h1F);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("post_drain_rst_flush", 32'(flush), 0);
      check("post_drain_rst_raddr", redirect_addr_o, 0);
      @(posedge clk);
      #1;
    end
    $display("reset mid-drain: redirect=%0b addr=0x%08h", redirect_o, redirect_addr_o);

    // Reset in the middle of a flush cycle.
    set_in(0, 0, 0, 1, 32'h700, 0, 0);
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("flush_before_rst", 32'(flush), 1);
    check("raddr_before_rst", redirect_addr_o, 32'h700);
    do_reset();
    $display("reset mid-flush: flush=%0b addr=0x%08h", flush, redirect_addr_o);

    // Counter saturation on the narrow instance.
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    @(negedge clk);
    check("sat_perf_narrow", 32'(s_perf), 32'd15);
    check("sat_perf_wide", perf_stall_cnt, 32'd20);
    $display("saturation: narrow=%0d wide=%0d", s_perf, perf_stall_cnt);

    // Randomized traffic against the model.
    do_reset();
    prev_mem = 1'b0;
    halt_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_halt && halt_cycles > 3) begin
        do_reset();
        halt_cycles = 0;
        prev_mem = 1'b0;
      end
      stallreq_id  = ($urandom_range(0, 99) < 25);
      stallreq_ex  = ($urandom_range(0, 99) < 15);
      stallreq_mem = ($urandom_range(0, 99) < (prev_mem ? 85 : 20));
      br_i         = ($urandom_range(0, 99) < 20);
      trap_i       = ($urandom_range(0, 99) < 8);
      br_addr_i    = $urandom;
      trap_vec_i   = $urandom;
      prev_mem     = stallreq_mem;
      model_cycle();
      if (m_halt) halt_cycles++;
      if (c % 500 == 499)
        $display("random: %0d cycles, perf=%0d, checks=%0d", c + 1, perf_stall_cnt, n_checks);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencing controller for the five-stage pipeline.
- Collects stall requests from the ID, EX and MEM stages, plus branch and trap redirect requests.
- Produces the 6-bit stall vector consumed by every pipeline register, and the PC redirect/flush controls.
- Also owns a stall-cycle performance counter and a MEM-wait watchdog that halts the pipeline on a hung bus.

Parameters:
- WDOG_CYC, 1024: consecutive cycles of stallreq_mem that trip the watchdog (must be ≥2).
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous reset, active-high.
- stallreq_id  input  1  load-use hazard hold request from ID.
- stallreq_ex  input  1  multi-cycle EX op busy.
- stallreq_mem  input  1  data memory not ready.
- br_i  input  1  taken branch/jump resolved in ID.
- br_addr_i  input  32  branch target.
- trap_i  input  1  exception/ecall raised.
- trap_vec_i  input  32  trap handler address.
- stall  output  6  hold enables: bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
- flush  output  1  clear IF/ID and ID/EX to bubbles.
- redirect_o  output  1  load PC from redirect_addr_o.
- redirect_addr_o  output  32  redirect target.
- bus_err_o  output  1  sticky watchdog error.
- perf_stall_cnt  output  CNT_W  count of cycles with stall != 0.

Behaviour:
- Reset values (asynchronous, immediate on rst=1):
  - state = RUN.
  - flush = 0, redirect_o = 0, redirect_addr_o = 0.
  - bus_err_o = 0, perf_stall_cnt = 0, watchdog counter = 0.
  - stall = 0.
- Base stall vector (combinational, priority mem > ex > id):
  - stallreq_mem → 6'b011111.
  - stallreq_ex → 6'b001111.
  - stallreq_id → 6'b000111.
  - no request → 6'b000000.
  - Requests with no stall effect ("pending") = any of the three asserted.
- State RUN:
  - stall = base.
  - trap_i=1 and nothing pending → latch trap_vec_i, go to FLUSH.
  - trap_i=1 with a request pending → latch trap_vec_i, go to DRAIN.
  - Otherwise br_i=1 and nothing pending → latch br_addr_i, go to FLUSH.
  - br_i while a request is pending is ignored; the source holds it because ID is frozen.
  - Trap beats branch in the same cycle.
- State DRAIN:
  - stall = base OR 6'b000011, so the front end stays frozen.
  - Further trap_i/br_i are ignored; the first trap wins.
  - Go to FLUSH on the first cycle with nothing pending.
- State FLUSH (exactly one cycle):
  - stall = 0, flush = 1, redirect_o = 1, redirect_addr_o = latched address.
  - Requests and br/trap are ignored; always return to RUN.
- Outside FLUSH: flush and redirect_o are 0, and redirect_addr_o holds its last value.
- Latency: redirect_o asserts in the cycle after br_i/trap_i is sampled with nothing pending.
- Watchdog:
  - Counts consecutive cycles with stallreq_mem=1; resets to 0 whenever stallreq_mem=0.
  - On reaching WDOG_CYC, set bus_err_o=1 and go to HALT from any state.
  - In HALT, stall = 6'b111111 and flush = redirect_o = 0; only rst exits.
- perf_stall_cnt:
  - Increments on each cycle where the stall output ≠ 0, HALT included.
  - Saturates at all-ones; no wrap.
- Reset mid-FLUSH or mid-DRAIN aborts the pending redirect; the latched address is cleared.

Test Plan:
- rst=1 for 3 cycles, then release with idle inputs → stall=0, flush=0, redirect_o=0, perf_stall_cnt=0.
- Priority:
  - stallreq_id=1 for 2 cycles → stall=000111 for both, then 0; perf_stall_cnt=2.
  - All three requests at once → stall=011111.
- br_i=1, br_addr_i=0x0000_0100, no requests → next cycle flush=1, redirect_o=1, redirect_addr_o=0x100, stall=0; following cycle back to 0.
- Trap during memory wait: stallreq_mem=1 for 4 cycles; trap_i=1 with trap_vec_i=0x8000_0000 in cycle 1, br_i=1 in cycle 2.
  - stall=011111 through the wait.
  - One cycle after stallreq_mem drops: redirect to 0x8000_0000; the branch is never taken.
- Simultaneous br_i=1 (0x200) and trap_i=1 (0x400), idle pipeline → redirect_addr_o=0x400.
- WDOG_CYC=8, stallreq_mem held high:
  - Cycle 8: bus_err_o=1, stall=111111.
  - Dropping stallreq_mem does not clear either; rst clears both.
